// File: rtl/ds_inst_queue_if.sv
// Fetch-to-decode queue handshake: payload in, head/issue status out.
interface ds_inst_queue_if #(
  parameter int BUS_WD = 64,
  parameter int DEPTH  = 4
);
  logic                     fs_to_ds_valid;
  logic [BUS_WD-1:0]        fs_to_ds_bus;
  logic                     ds_allowin;
  logic                     stallD;
  logic                     es_allowin;
  logic                     ds_to_es_valid;
  logic                     ds_head_valid;
  logic [BUS_WD-1:0]        ds_head_bus;
  logic [$clog2(DEPTH):0]   ds_count;
  logic                     flush;

  modport master (
    output fs_to_ds_valid, fs_to_ds_bus, stallD, es_allowin, flush,
    input  ds_allowin, ds_to_es_valid, ds_head_valid, ds_head_bus, ds_count
  );

  modport slave (
    input  fs_to_ds_valid, fs_to_ds_bus, stallD, es_allowin, flush,
    output ds_allowin, ds_to_es_valid, ds_head_valid, ds_head_bus, ds_count
  );
endinterface

// File: rtl/ds_inst_queue.sv
// Decode-stage in-order instruction queue with branch flush (delay slot kept)
// and prioritised rs/rt operand bypass for the head instruction.
module ds_inst_queue #(
  parameter int BUS_WD  = 64,
  parameter int DEPTH   = 4,
  parameter int NUM_FWD = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  ds_inst_queue_if.slave       q,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic [NUM_FWD-1:0]   fwd_valid,
  input  logic [5*NUM_FWD-1:0] fwd_addr,
  input  logic [32*NUM_FWD-1:0] fwd_data,
  output logic [31:0]          rs_value,
  output logic [31:0]          rt_value
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BUS_WD-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CW-1:0]     count, cnt_nxt, keep;
  logic              push, pop, flush_eff, wr_en;
  logic [4:0]        rs, rt;

  assign q.ds_allowin     = (count < CW'(DEPTH));
  assign q.ds_head_valid  = (count != '0);
  assign q.ds_to_es_valid = q.ds_head_valid && !q.stallD;
  assign q.ds_count       = count;
  assign q.ds_head_bus    = mem[rd_ptr];

  assign push      = q.fs_to_ds_valid && q.ds_allowin;
  assign pop       = q.ds_to_es_valid && q.es_allowin;
  assign flush_eff = q.flush && (count != '0);

  always_comb begin
    keep    = (count > CW'(2)) ? CW'(2) : count;
    wr_en   = push;
    rd_nxt  = rd_ptr + PW'(pop);
    wr_nxt  = wr_ptr + PW'(push);
    cnt_nxt = count + CW'(push) - CW'(pop);
    // On flush, wr_ptr is rebuilt from rd_ptr so wrong-path entries vanish;
    // a push survives only as the delay slot behind a lone head.
    if (flush_eff) begin
      wr_en   = push && (count == CW'(1));
      wr_nxt  = rd_ptr + PW'(keep) + PW'(wr_en);
      cnt_nxt = keep + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= q.fs_to_ds_bus;
  end

  assign rs = q.ds_head_bus[57:53];
  assign rt = q.ds_head_bus[52:48];

  // Scan from lowest priority upward so the lowest matching index wins.
  always_comb begin
    rs_value = rf_rdata1;
    rt_value = rf_rdata2;
    for (int unsigned i = NUM_FWD; i > 0; i--) begin
      if (fwd_valid[i-1] && fwd_addr[5*(i-1) +: 5] == rs && rs != 5'd0)
        rs_value = fwd_data[32*(i-1) +: 32];
      if (fwd_valid[i-1] && fwd_addr[5*(i-1) +: 5] == rt && rt != 5'd0)
        rt_value = fwd_data[32*(i-1) +: 32];
    end
  end
endmodule

// File: tb/tb_ds_inst_queue.sv
// Directed bench for ds_inst_queue: forwarding vector table plus queue sequences.
module tb_ds_inst_queue;
  logic        clk = 0;
  logic        reset;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [31:0] rs_value, rt_value;

  int checks = 0;
  int errors = 0;

  ds_inst_queue_if #(.BUS_WD(64), .DEPTH(4)) q ();

  ds_inst_queue #(.BUS_WD(64), .DEPTH(4), .NUM_FWD(3)) dut (
    .clk(clk), .reset(reset), .q(q),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rs_value(rs_value), .rt_value(rt_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fv;
    logic [14:0] fa;
    logic [95:0] fd;
    logic [31:0] ers;
    logic [31:0] ert;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pc(input logic [31:0] pc);
    q.fs_to_ds_valid = 1;
    q.fs_to_ds_bus   = {32'h0, pc};
    tick();
    q.fs_to_ds_valid = 0;
  endtask

  initial begin
    reset = 1;
    q.fs_to_ds_valid = 0; q.fs_to_ds_bus = '0; q.stallD = 0;
    q.es_allowin = 0; q.flush = 0;
    rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0;

    vecs[0] = '{inst: mk_inst(5, 7),  fv: 3'b101, fa: {5'd5, 5'd0, 5'd5},
                fd: {32'hC, 32'hB, 32'hA}, ers: 32'hA,  ert: 32'h22};
    vecs[1] = '{inst: mk_inst(0, 7),  fv: 3'b111, fa: {5'd0, 5'd7, 5'd0},
                fd: {32'hC, 32'hB, 32'hA}, ers: 32'h11, ert: 32'hB};
    vecs[2] = '{inst: mk_inst(3, 3),  fv: 3'b110, fa: {5'd3, 5'd9, 5'd3},
                fd: {32'hC, 32'hB, 32'hA}, ers: 32'hC,  ert: 32'hC};
    vecs[3] = '{inst: mk_inst(8, 9),  fv: 3'b000, fa: {5'd8, 5'd9, 5'd8},
                fd: {32'hC, 32'hB, 32'hA}, ers: 32'h11, ert: 32'h22};
    vecs[4] = '{inst: mk_inst(31, 31), fv: 3'b011, fa: {5'd0, 5'd31, 5'd31},
                fd: {32'hC, 32'hB, 32'hA}, ers: 32'hA,  ert: 32'hA};
    vecs[5] = '{inst: mk_inst(4, 0),  fv: 3'b111, fa: {5'd0, 5'd4, 5'd1},
                fd: {32'hC, 32'hB, 32'hA}, ers: 32'hB,  ert: 32'h22};

    #12;
    chk("rst_count", 64'(q.ds_count), 64'd0);
    chk("rst_allowin", 64'(q.ds_allowin), 64'd1);
    chk("rst_head_valid", 64'(q.ds_head_valid), 64'd0);
    chk("rst_to_es", 64'(q.ds_to_es_valid), 64'd0);
    reset = 0;
    tick();

    // Fill/drain
    for (int k = 0; k < 5; k++) begin
      q.fs_to_ds_valid = 1;
      q.fs_to_ds_bus   = {32'h0, 32'h100 + 32'(4*k)};
      #1 chk($sformatf("fill_allowin%0d", k), 64'(q.ds_allowin), (k < 4) ? 64'd1 : 64'd0);
      tick();
    end
    q.fs_to_ds_valid = 0;
    chk("full_count", 64'(q.ds_count), 64'd4);
    chk("full_allowin", 64'(q.ds_allowin), 64'd0);
    q.es_allowin = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("drain_valid%0d", k), 64'(q.ds_to_es_valid), 64'd1);
      chk($sformatf("drain_pc%0d", k), 64'(q.ds_head_bus[31:0]), 64'(32'h100 + 32'(4*k)));
      tick();
    end
    chk("drain_count", 64'(q.ds_count), 64'd0);

    // Wrap-around: continuous push and pop
    q.fs_to_ds_valid = 1;
    for (int j = 0; j <= 10; j++) begin
      q.fs_to_ds_bus = {32'h0, 32'h500 + 32'(4*j)};
      if (j > 0) begin
        #1 chk($sformatf("wrap_count%0d", j), 64'(q.ds_count), 64'd1);
        chk($sformatf("wrap_pc%0d", j), 64'(q.ds_head_bus[31:0]), 64'(32'h500 + 32'(4*(j-1))));
      end
      tick();
    end
    q.fs_to_ds_valid = 0;
    tick();
    chk("wrap_empty", 64'(q.ds_count), 64'd0);

    // Stall
    push_pc(32'h200);
    q.stallD = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall_to_es%0d", k), 64'(q.ds_to_es_valid), 64'd0);
      chk($sformatf("stall_head%0d", k), 64'(q.ds_head_bus[31:0]), 64'h200);
      tick();
    end
    q.stallD = 0;
    #1 chk("stall_release", 64'(q.ds_to_es_valid), 64'd1);
    chk("stall_release_pc", 64'(q.ds_head_bus[31:0]), 64'h200);
    tick();
    chk("stall_count", 64'(q.ds_count), 64'd0);

    // Flush with delay slot, head pops
    q.es_allowin = 0;
    for (int k = 0; k < 4; k++) push_pc(32'h300 + 32'(4*k));
    q.flush = 1; q.es_allowin = 1;
    #1 chk("fl_pop_to_es", 64'(q.ds_to_es_valid), 64'd1);
    chk("fl_pop_head", 64'(q.ds_head_bus[31:0]), 64'h300);
    tick();
    q.flush = 0; q.es_allowin = 0;
    chk("fl_pop_count", 64'(q.ds_count), 64'd1);
    chk("fl_pop_slot", 64'(q.ds_head_bus[31:0]), 64'h304);
    q.es_allowin = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fl_gone_valid%0d", k), 64'(q.ds_to_es_valid), 64'd0);
      chk($sformatf("fl_gone_count%0d", k), 64'(q.ds_count), 64'd0);
      tick();
    end

    // Flush with count 1 and simultaneous push
    q.es_allowin = 0;
    push_pc(32'h400);
    q.flush = 1;
    q.fs_to_ds_valid = 1; q.fs_to_ds_bus = {32'h0, 32'h404};
    #1 chk("fl1_allowin", 64'(q.ds_allowin), 64'd1);
    tick();
    q.flush = 0; q.fs_to_ds_valid = 0;
    chk("fl1_count", 64'(q.ds_count), 64'd2);
    chk("fl1_head0", 64'(q.ds_head_bus[31:0]), 64'h400);
    q.es_allowin = 1;
    tick();
    chk("fl1_head1", 64'(q.ds_head_bus[31:0]), 64'h404);
    tick();
    chk("fl1_empty", 64'(q.ds_count), 64'd0);

    // Flush with count 3: push dropped though allowin is high
    q.es_allowin = 0;
    for (int k = 0; k < 3; k++) push_pc(32'h600 + 32'(4*k));
    q.flush = 1;
    q.fs_to_ds_valid = 1; q.fs_to_ds_bus = {32'h0, 32'h60C};
    #1 chk("fl3_allowin", 64'(q.ds_allowin), 64'd1);
    tick();
    q.flush = 0; q.fs_to_ds_valid = 0;
    chk("fl3_count", 64'(q.ds_count), 64'd2);
    q.es_allowin = 1;
    chk("fl3_head0", 64'(q.ds_head_bus[31:0]), 64'h600);
    tick();
    chk("fl3_head1", 64'(q.ds_head_bus[31:0]), 64'h604);
    tick();
    chk("fl3_empty", 64'(q.ds_count), 64'd0);

    // Asynchronous reset mid-operation
    q.es_allowin = 0;
    push_pc(32'h700);
    push_pc(32'h704);
    #2 reset = 1;
    #1 chk("mid_rst_count", 64'(q.ds_count), 64'd0);
    chk("mid_rst_head_valid", 64'(q.ds_head_valid), 64'd0);
    tick();
    reset = 0;
    push_pc(32'h708);
    chk("post_rst_count", 64'(q.ds_count), 64'd1);
    chk("post_rst_head", 64'(q.ds_head_bus[31:0]), 64'h708);
    q.es_allowin = 1;
    tick();
    q.es_allowin = 0;

    // Forwarding vector table
    for (int v = 0; v < 6; v++) begin
      q.fs_to_ds_valid = 1;
      q.fs_to_ds_bus   = {vecs[v].inst, 32'h800 + 32'(4*v)};
      tick();
      q.fs_to_ds_valid = 0;
      fwd_valid = vecs[v].fv; fwd_addr = vecs[v].fa; fwd_data = vecs[v].fd;
      #1 chk($sformatf("fwd_rs%0d", v), 64'(rs_value), 64'(vecs[v].ers));
      chk($sformatf("fwd_rt%0d", v), 64'(rt_value), 64'(vecs[v].ert));
      fwd_valid = '0;
      q.es_allowin = 1;
      tick();
      q.es_allowin = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ds_inst_queue.md
# ds_inst_queue

Parametrised decode-stage front end that replaces the single fs_to_ds register with a DEPTH-entry in-order queue of fetched {inst, pc} payloads. It sits between fetch and decode logic and:
- drives the valid/allowin handshake on both sides;
- honours the hazard stall;
- flushes wrong-path entries on a taken branch, keeping the delay slot;
- selects forwarded rs/rt operand values from NUM_FWD prioritised bypass sources for the instruction at the head.

## Interface

Parameters:
- BUS_WD, 64: payload width; {inst, pc} with inst at [63:32], pc at [31:0]; must be >= 64.
- DEPTH, 4: queue entries; power of two, >= 2.
- NUM_FWD, 3: number of bypass sources; index 0 has highest priority (youngest producer).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fs_to_ds_valid  in  1  fetch payload valid.
- fs_to_ds_bus  in  BUS_WD  fetch payload.
- ds_allowin  out  1  queue can accept a payload this cycle.
- stallD  in  1  hazard stall; head must not issue.
- es_allowin  in  1  execute stage accepts.
- ds_to_es_valid  out  1  head issues this cycle.
- ds_head_valid  out  1  queue non-empty (gates hazard-unit use of rs/rt).
- ds_head_bus  out  BUS_WD  oldest entry; don't-care when ds_head_valid=0.
- ds_count  out  clog2(DEPTH)+1  occupancy.
- flush  in  1  taken branch resolved for the head instruction.
- rf_rdata1, rf_rdata2  in  32 each  regfile reads for head rs/rt.
- fwd_valid  in  NUM_FWD  bypass source i writes a register.
- fwd_addr  in  5*NUM_FWD  dest of source i at [5i+4:5i].
- fwd_data  in  32*NUM_FWD  result of source i at [32i+31:32i].
- rs_value, rt_value  out  32 each  forwarded operands for the head.

## Operation

- push = fs_to_ds_valid && ds_allowin; pop = ds_to_es_valid && es_allowin.
- ds_allowin = (ds_count < DEPTH). No pop-through when full: a full queue refuses a push even in a pop cycle.
- ds_head_valid = (ds_count != 0).
- ds_to_es_valid = ds_head_valid && !stallD.
- Storage is a circular buffer with rd_ptr and wr_ptr, each clog2(DEPTH) bits and wrapping modulo DEPTH, plus ds_count.
- Simultaneous push and pop: count unchanged, both pointers advance.
- rs = head inst[25:21]; rt = head inst[20:16].
- rs_value is fwd_data[i] for the lowest i with fwd_valid[i] && fwd_addr[i]==rs && rs!=0; otherwise rf_rdata1. rt_value is the same using rt and rf_rdata2.
- Register 0 is never forwarded.
- Flush (ignored when ds_count==0). In the flush cycle:
  - Retained entries are the head and the delay slot (entry head+1) if present. All younger entries are discarded: wr_ptr = rd_ptr + min(ds_count, 2).
  - If the head also pops, only the delay slot remains.
  - An incoming push is written only when ds_count==1; it becomes the delay slot. Otherwise the push is dropped, although ds_allowin still reflects the pre-flush count.
  - ds_count_next = min(ds_count,2) - pop + (push && ds_count==1).

## Timing

- Reset (asynchronous, takes effect immediately): ds_count=0 and both pointers=0. Outputs: ds_allowin=1, ds_head_valid=0, ds_to_es_valid=0. Payload storage is not reset.
- Latency: an entry pushed at edge N is visible on ds_head_bus and ds_head_valid after edge N; it can issue in cycle N+1 at the earliest.
- Sequential outputs: ds_allowin, ds_head_valid and ds_count are functions of registered state only.
- Combinational outputs: ds_to_es_valid depends combinationally on stallD; rs_value and rt_value depend combinationally on the fwd_* and rf_rdata* inputs.
- Reset asserted mid-operation discards all entries. The first push after deassertion lands in entry 0.
- Flush takes effect at the edge ending the flush cycle. Discarded entries never assert ds_to_es_valid.

## Test plan

- Fill/drain: es_allowin=0, push 5 payloads with pc 0x100..0x110 at DEPTH=4. Required: ds_allowin drops after the 4th push, the 5th is not accepted, ds_count=4. Release es_allowin: pcs issue in order 0x100..0x10C, and ds_count reaches 0.
- Wrap-around: continuous push and pop for 10 cycles with stallD=0. Required: pc order preserved across pointer wrap, and ds_count constant at 1 after the first cycle.
- Stall: head pc 0x200, stallD=1 for 3 cycles. Required: ds_to_es_valid=0 throughout, head unchanged, then it issues in the first cycle with stallD=0.
- Flush with delay slot: queue holds pcs 0x300, 0x304, 0x308, 0x30C; flush with pop. Required: next cycle ds_count=1, head=0x304, and 0x308/0x30C never issue.
- Flush with count 1: head 0x400, flush, no pop, simultaneous push of 0x404. Required: ds_count=2 and order 0x400, 0x404.
- Forwarding priority: head rs=5, fwd0 and fwd2 both target r5 with data 0xA and 0xC. Required: rs_value=0xA. With rs=0 and fwd0 targeting r0, rs_value=rf_rdata1.
